// File: rtl/pong_match_ctrl.sv
// -----------------------------------------------------------------------------
// pong_match_ctrl
//
// Match sequencer for the pingpong game. It sits between the VGA frame timing
// and the board/ball movers. It decides when the movers step, detects paddle
// hits and misses at the top and bottom edges, keeps score, runs the serve and
// point pauses, and declares a winner. The movers own their coordinate
// registers; this block only drives their enables and bounce/reset strobes.
//
// Optional feature: define PONG_PAUSE_EN to enable the PLAY <-> PAUSE toggle
// driven by pause_btn. Without it, pause_btn is unused and PAUSE is unreachable.
//
// Ports
//   pixel_clk   in   1   pixel clock
//   rst_n       in   1   synchronous active-low reset
//   frame_tick  in   1   1-cycle pulse at the end of each visible frame
//   logo_done   in   1   level, high once the logo splash has finished
//   start_btn   in   1   level, debounced; starts or restarts a match
//   pause_btn   in   1   1-cycle pulse; only used with PONG_PAUSE_EN
//   ball_h      in  10   ball top-left x
//   ball_v      in  10   ball top-left y
//   board1_h    in  10   top paddle left x (paddle at v=0)
//   board2_h    in  10   bottom paddle left x (paddle at v=SCREEN_V-BOARD_H)
//   step_en     out  1   1-cycle pulse: movers advance one step
//   bounce_v    out  1   1-cycle pulse: ball reverses vertical direction
//   ball_reset  out  1   1-cycle pulse: ball returns to centre
//   serve_down  out  1   serve direction, 1 = toward board2
//   score1      out  4   top player score
//   score2      out  4   bottom player score
//   winner      out  2   00 none, 01 player1, 10 player2
//   state       out  3   IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4 PAUSE=5
// -----------------------------------------------------------------------------
module pong_match_ctrl #(
  parameter int FRAMES_PER_ACTION = 2,
  parameter int SERVE_FRAMES      = 60,
  parameter int POINT_FRAMES      = 90,
  parameter int WIN_SCORE         = 7,
  parameter int SCREEN_V          = 600,
  parameter int BOARD_W           = 100,
  parameter int BOARD_H           = 20,
  parameter int BALL_S            = 16
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       logo_done,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic [9:0] ball_h,
  input  logic [9:0] ball_v,
  input  logic [9:0] board1_h,
  input  logic [9:0] board2_h,
  output logic       step_en,
  output logic       bounce_v,
  output logic       ball_reset,
  output logic       serve_down,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4,
    ST_PAUSE = 3'd5
  } state_t;

  // One shared frame counter serves SERVE, PLAY and POINT; size it for the
  // longest hold.
  localparam int CNT_MAX_A = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_MAX   = (CNT_MAX_A > FRAMES_PER_ACTION) ? CNT_MAX_A : FRAMES_PER_ACTION;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SERVE_LAST  = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LAST  = CNT_W'(POINT_FRAMES - 1);
  localparam logic [CNT_W-1:0] ACTION_LAST = CNT_W'(FRAMES_PER_ACTION);
  localparam logic [3:0]       WIN_VAL     = 4'(WIN_SCORE);

  // Geometry is evaluated at 11 bits so x + width never wraps.
  localparam logic [10:0] TOP_LIMIT = 11'(BOARD_H);
  localparam logic [10:0] BOT_LIMIT = 11'(SCREEN_V - BOARD_H);
  localparam logic [10:0] BALL_S_X  = 11'(BALL_S);
  localparam logic [10:0] BOARD_W_X = 11'(BOARD_W);

  state_t           cur_state, nxt_state;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_nxt;

  logic       step_nxt, bounce_nxt, reset_nxt, serve_down_nxt;
  logic [3:0] score1_nxt, score2_nxt;
  logic [1:0] winner_nxt;

  // ---------------------------------------------------------------------------
  // Collision geometry
  // ---------------------------------------------------------------------------
  logic [10:0] ball_h_x, ball_v_x, board1_x, board2_x;
  logic [10:0] ball_right, board1_right, board2_right;
  logic        top_zone, bot_zone, top_hit, bot_hit, top_miss, bot_miss;

  assign ball_h_x     = {1'b0, ball_h};
  assign ball_v_x     = {1'b0, ball_v};
  assign board1_x     = {1'b0, board1_h};
  assign board2_x     = {1'b0, board2_h};
  assign ball_right   = ball_h_x + BALL_S_X;
  assign board1_right = board1_x + BOARD_W_X;
  assign board2_right = board2_x + BOARD_W_X;

  assign top_zone = (ball_v_x <= TOP_LIMIT);
  assign bot_zone = (ball_v_x + BALL_S_X >= BOT_LIMIT);
  assign top_hit  = (ball_right >= board1_x) && (ball_h_x <= board1_right);
  assign bot_hit  = (ball_right >= board2_x) && (ball_h_x <= board2_right);
  // The top zone wins if both zones ever overlap in one step.
  assign top_miss = top_zone && !top_hit;
  assign bot_miss = !top_zone && bot_zone && !bot_hit;

  // ---------------------------------------------------------------------------
  // Events shared by the next-state and output logic
  // ---------------------------------------------------------------------------
  logic pause_req, resume_req;

`ifdef PONG_PAUSE_EN
  assign pause_req  = pause_btn && (cur_state == ST_PLAY);
  assign resume_req = pause_btn && (cur_state == ST_PAUSE);
`else
  logic unused_pause;
  assign unused_pause = pause_btn;
  assign pause_req    = 1'b0;
  assign resume_req   = 1'b0;
`endif

  logic start_go, step_tick, point_done, point_won;

  assign start_go   = ((cur_state == ST_IDLE) && logo_done && start_btn) ||
                      ((cur_state == ST_OVER) && start_btn);
  // A pause request in the same cycle as a step tick takes precedence.
  assign step_tick  = (cur_state == ST_PLAY) && frame_tick && !pause_req &&
                      (frame_cnt == '0);
  assign point_done = (cur_state == ST_POINT) && frame_tick && (frame_cnt == POINT_LAST);
  assign point_won  = (score1 == WIN_VAL) || (score2 == WIN_VAL);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: every register here uses <= so all flops sample the same pre-edge
  // values; a blocking = would let later lines see already-updated state.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      cur_state  <= ST_IDLE;
      frame_cnt  <= '0;
      step_en    <= 1'b0;
      bounce_v   <= 1'b0;
      ball_reset <= 1'b0;
      serve_down <= 1'b1;
      score1     <= '0;
      score2     <= '0;
      winner     <= 2'b00;
    end else begin
      cur_state  <= nxt_state;
      frame_cnt  <= frame_cnt_nxt;
      step_en    <= step_nxt;
      bounce_v   <= bounce_nxt;
      ball_reset <= reset_nxt;
      serve_down <= serve_down_nxt;
      score1     <= score1_nxt;
      score2     <= score2_nxt;
      winner     <= winner_nxt;
    end
  end

  assign state = cur_state;

  // ---------------------------------------------------------------------------
  // Next-state and frame counter
  // ---------------------------------------------------------------------------
  // NOTE: every signal written below gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    nxt_state     = cur_state;
    frame_cnt_nxt = frame_cnt;
    unique case (cur_state)
      ST_IDLE: begin
        if (start_go) nxt_state = ST_SERVE;
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (frame_cnt == SERVE_LAST) nxt_state = ST_PLAY;
          else frame_cnt_nxt = frame_cnt + 1'b1;
        end
      end
      ST_PLAY: begin
        if (pause_req) begin
          nxt_state = ST_PAUSE;
        end else if (frame_tick) begin
          frame_cnt_nxt = (frame_cnt == ACTION_LAST) ? '0 : frame_cnt + 1'b1;
          if ((frame_cnt == '0) && (top_miss || bot_miss)) nxt_state = ST_POINT;
        end
      end
      ST_POINT: begin
        if (frame_tick) begin
          if (frame_cnt == POINT_LAST) nxt_state = point_won ? ST_OVER : ST_SERVE;
          else frame_cnt_nxt = frame_cnt + 1'b1;
        end
      end
      ST_OVER: begin
        if (start_go) nxt_state = ST_SERVE;
      end
      ST_PAUSE: begin
        if (resume_req) nxt_state = ST_PLAY;
      end
      default: nxt_state = ST_IDLE;
    endcase
    // Any state change restarts frame counting, except the pause toggle,
    // which must resume PLAY exactly where it left off.
    if ((nxt_state != cur_state) && !pause_req && !resume_req) frame_cnt_nxt = '0;
  end

  // ---------------------------------------------------------------------------
  // Next values of the registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    step_nxt       = 1'b0;
    bounce_nxt     = 1'b0;
    reset_nxt      = 1'b0;
    serve_down_nxt = serve_down;
    score1_nxt     = score1;
    score2_nxt     = score2;
    winner_nxt     = winner;

    if (start_go) begin
      reset_nxt  = 1'b1;
      score1_nxt = '0;
      score2_nxt = '0;
      winner_nxt = 2'b00;
    end

    if (step_tick) begin
      step_nxt = 1'b1;
      if (top_zone) begin
        if (top_hit) begin
          bounce_nxt = 1'b1;
        end else begin
          score2_nxt     = sat_inc(score2);
          serve_down_nxt = 1'b0;
        end
      end else if (bot_zone) begin
        if (bot_hit) begin
          bounce_nxt = 1'b1;
        end else begin
          score1_nxt     = sat_inc(score1);
          serve_down_nxt = 1'b1;
        end
      end
    end

    if (point_done) begin
      if (score1 == WIN_VAL)      winner_nxt = 2'b01;
      else if (score2 == WIN_VAL) winner_nxt = 2'b10;
      else                        reset_nxt  = 1'b1;
    end
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_match_ctrl
//
// Randomized scoreboard bench for pong_match_ctrl. A game-level reference
// model (tick counts, scores, play-tick modulo) predicts each strobe; the
// expected output snapshot and its cycle are queued, and an independent
// monitor pops and compares whenever the DUT raises a strobe. Full output
// snapshots are also compared at every model state change.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pong_match_ctrl;

  localparam int FPA          = 2;
  localparam int SERVE_FRAMES = 60;
  localparam int POINT_FRAMES = 90;
  localparam int WIN_SCORE    = 7;
  localparam int SCREEN_V     = 600;
  localparam int BOARD_W      = 100;
  localparam int BOARD_H      = 20;
  localparam int BALL_S       = 16;

`ifdef PONG_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4, M_PAUSE = 5;

  logic       pixel_clk  = 1'b0;
  logic       rst_n      = 1'b0;
  logic       frame_tick = 1'b0;
  logic       logo_done  = 1'b0;
  logic       start_btn  = 1'b0;
  logic       pause_btn  = 1'b0;
  logic [9:0] ball_h     = '0;
  logic [9:0] ball_v     = '0;
  logic [9:0] board1_h   = '0;
  logic [9:0] board2_h   = '0;
  logic       step_en, bounce_v, ball_reset, serve_down;
  logic [3:0] score1, score2;
  logic [1:0] winner;
  logic [2:0] state;

  pong_match_ctrl dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .logo_done (logo_done),
    .start_btn (start_btn),
    .pause_btn (pause_btn),
    .ball_h    (ball_h),
    .ball_v    (ball_v),
    .board1_h  (board1_h),
    .board2_h  (board2_h),
    .step_en   (step_en),
    .bounce_v  (bounce_v),
    .ball_reset(ball_reset),
    .serve_down(serve_down),
    .score1    (score1),
    .score2    (score2),
    .winner    (winner),
    .state     (state)
  );

  always #14 pixel_clk = ~pixel_clk;

  int unsigned cyc = 0;
  always @(posedge pixel_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       stp;
    logic       bnc;
    logic       rst;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] win;
    logic       sd;
    logic [2:0] st;
  } snap_t;

  typedef struct {
    int unsigned cyc;
    snap_t       s;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: game rules in terms of tick counts
  // ---------------------------------------------------------------------------
  int m_st, m_ticks, m_play, m_s1, m_s2, m_win;
  bit m_sd;
  bit model_valid = 1'b0;
  bit need_check  = 1'b0;
  bit last_stp, last_bnc, last_rs;
  int overs = 0;

  function automatic snap_t model_snap(input bit a, input bit b, input bit c);
    snap_t s;
    s.stp = a;
    s.bnc = b;
    s.rst = c;
    s.s1  = 4'(m_s1);
    s.s2  = 4'(m_s2);
    s.win = (m_win == 1) ? 2'b01 : (m_win == 2) ? 2'b10 : 2'b00;
    s.sd  = m_sd;
    s.st  = 3'(m_st);
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.stp = step_en;
    s.bnc = bounce_v;
    s.rst = ball_reset;
    s.s1  = score1;
    s.s2  = score2;
    s.win = winner;
    s.sd  = serve_down;
    s.st  = state;
    return s;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_ticks = 0; m_play = 0;
    m_s1 = 0; m_s2 = 0; m_win = 0; m_sd = 1'b1;
    model_valid = 1'b1;
  endtask

  task automatic new_match(output bit rs);
    rs = 1'b1; m_s1 = 0; m_s2 = 0; m_win = 0;
    m_st = M_SERVE; m_ticks = 0;
  endtask

  task automatic model_cycle(input bit tick, input bit logo, input bit start, input bit pause,
                             input int bv, input int bh, input int b1, input int b2,
                             output bit stp, output bit bnc, output bit rs);
    stp = 1'b0; bnc = 1'b0; rs = 1'b0;
    case (m_st)
      M_IDLE:  if (logo && start) new_match(rs);
      M_OVER:  if (start) new_match(rs);
      M_SERVE: if (tick) begin
        m_ticks++;
        if (m_ticks == SERVE_FRAMES) begin m_st = M_PLAY; m_play = 0; end
      end
      M_PLAY: begin
        if (PAUSE_EN && pause) m_st = M_PAUSE;
        else if (tick) begin
          if (m_play % (FPA + 1) == 0) begin
            stp = 1'b1;
            if (bv <= BOARD_H) begin
              if (bh + BALL_S >= b1 && bh <= b1 + BOARD_W) bnc = 1'b1;
              else begin
                m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15; m_sd = 1'b0;
                m_st = M_POINT; m_ticks = 0;
              end
            end else if (bv + BALL_S >= SCREEN_V - BOARD_H) begin
              if (bh + BALL_S >= b2 && bh <= b2 + BOARD_W) bnc = 1'b1;
              else begin
                m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15; m_sd = 1'b1;
                m_st = M_POINT; m_ticks = 0;
              end
            end
          end
          m_play++;
        end
      end
      M_POINT: if (tick) begin
        m_ticks++;
        if (m_ticks == POINT_FRAMES) begin
          if (m_s1 == WIN_SCORE)      begin m_win = 1; m_st = M_OVER; end
          else if (m_s2 == WIN_SCORE) begin m_win = 2; m_st = M_OVER; end
          else begin rs = 1'b1; m_st = M_SERVE; m_ticks = 0; end
        end
      end
      M_PAUSE: if (pause) m_st = M_PLAY;
      default: m_st = M_IDLE;
    endcase
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle of stimulus, applied on the falling edge
  // ---------------------------------------------------------------------------
  task automatic run_cycle(input bit rst_in, input bit tick, input bit logo, input bit start,
                           input bit pause, input int bv, input int bh, input int b1, input int b2);
    bit stp, bnc, rs;
    int prev_st, prev_win;
    @(negedge pixel_clk);
    if (model_valid && (need_check || (cyc % 16) == 0))
      check("snapshot", 32'(dut_snap()), 32'(model_snap(last_stp, last_bnc, last_rs)));
    rst_n      = rst_in;
    frame_tick = tick;
    logo_done  = logo;
    start_btn  = start;
    pause_btn  = pause;
    ball_v     = 10'(bv);
    ball_h     = 10'(bh);
    board1_h   = 10'(b1);
    board2_h   = 10'(b2);
    prev_st  = m_st;
    prev_win = m_win;
    if (!rst_in) begin
      model_reset();
      stp = 1'b0; bnc = 1'b0; rs = 1'b0;
    end else begin
      model_cycle(tick, logo, start, pause, bv, bh, b1, b2, stp, bnc, rs);
    end
    if (stp || bnc || rs) sb_q.push_back('{cyc: cyc + 1, s: model_snap(stp, bnc, rs)});
    if (m_st == M_OVER && prev_st != M_OVER) overs++;
    need_check = !rst_in || (m_st != prev_st) || (m_win != prev_win) || stp || bnc || rs;
    last_stp = stp; last_bnc = bnc; last_rs = rs;
  endtask

  // Random cycle biased toward the zone and paddle-edge boundaries.
  task automatic rand_cycle();
    int b1, b2, bv, bh, ref_b;
    b1 = ($urandom_range(0, 15) == 0) ? 1000 : int'($urandom_range(0, 699));
    b2 = ($urandom_range(0, 15) == 0) ? 1000 : int'($urandom_range(0, 699));
    case ($urandom_range(0, 7))
      0:       bv = BOARD_H;
      1:       bv = BOARD_H + 1;
      2:       bv = SCREEN_V - BOARD_H - BALL_S;
      3:       bv = SCREEN_V - BOARD_H - BALL_S - 1;
      4:       bv = 10;
      5:       bv = 570;
      default: bv = int'($urandom_range(0, 583));
    endcase
    ref_b = (bv <= 300) ? b1 : b2;
    case ($urandom_range(0, 6))
      0:       bh = ref_b - BALL_S;
      1:       bh = ref_b - BALL_S - 1;
      2:       bh = ref_b + BOARD_W;
      3:       bh = ref_b + BOARD_W + 1;
      4:       bh = ref_b + 10;
      default: bh = int'($urandom_range(0, 783));
    endcase
    if (bh < 0) bh = 0;
    if (bh > 1023) bh = 1023;
    run_cycle(1'b1, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 49) == 0, $urandom_range(0, 39) == 0, bv, bh, b1, b2);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops the scoreboard whenever the DUT raises a strobe
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(posedge pixel_clk);
      #1;
      if (step_en === 1'b1 || bounce_v === 1'b1 || ball_reset === 1'b1) begin
        check("strobe_expected", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("strobe_cycle", cyc, e.cyc);
          check("strobe_snap", 32'(dut_snap()), 32'(e.s));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int guard;
    repeat (4) run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10, 10, 350, 350);
    // start_btn without logo_done must be ignored
    repeat (5) run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 300, 400, 350, 350);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 300, 400, 350, 350);

    guard = 0;
    while (overs < 2 && guard < 30000) begin rand_cycle(); guard++; end
    check("two_matches_done", 32'(overs >= 2), 32'd1);

    guard = 0;
    while (!(m_st == M_POINT && m_ticks >= 10) && guard < 20000) begin rand_cycle(); guard++; end
    check("reached_point", 32'(m_st), 32'(M_POINT));
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10, 10, 350, 350);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 300, 400, 350, 350);
    check("reset_state", 32'(state), 32'(M_IDLE));
    check("reset_scores", 32'({score1, score2}), 32'd0);
    check("reset_strobes", 32'({step_en, bounce_v, ball_reset}), 32'd0);

    run_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 300, 400, 350, 350);
    repeat (3000) rand_cycle();

    repeat (4) run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 300, 400, 350, 350);
    @(posedge pixel_clk);
    #2;
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
